// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the core LSU (r0)
// and the debug loader (r1); partial stores are performed as read-modify-write.
module dmem_arbiter #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_be,
    output logic        r0_rsp_valid,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_be,
    output logic        r1_rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nx;
    logic        last_grant;
    logic        req_id, req_we, req_err;
    logic [31:0] req_addr, req_wdata, buffer;
    logic [3:0]  req_be;

    logic        gnt_id, take, sel_we, sel_err;
    logic [31:0] sel_addr, sel_wdata, merged;
    logic [3:0]  sel_be;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        gnt_id = 1'b0;
        if (r0_valid && r1_valid) gnt_id = ~last_grant;
        else if (r1_valid)        gnt_id = 1'b1;
        take      = (state == IDLE) && (r0_valid || r1_valid) && !rst;
        r0_ready  = take && !gnt_id;
        r1_ready  = take && gnt_id;
        sel_we    = gnt_id ? r1_we    : r0_we;
        sel_addr  = gnt_id ? r1_addr  : r0_addr;
        sel_wdata = gnt_id ? r1_wdata : r0_wdata;
        sel_be    = gnt_id ? r1_be    : r0_be;
        sel_err   = sel_addr >= ADDR_LIMIT;
    end

    // Store merge: enabled bytes from the request, the rest from the read buffer.
    always_comb begin
        merged = buffer;
        for (int i = 0; i < 4; i++) begin
            if (req_be[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nx     = state;
        mem_we       = 1'b0;
        mem_a        = 32'h0;
        mem_wd       = 32'h0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        rsp_rdata    = 32'h0;
        rsp_err      = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    if (sel_err)                            state_nx = RESP;
                    else if (sel_we && sel_be == 4'hF)      state_nx = WR;
                    else if (sel_we && sel_be == 4'h0)      state_nx = RESP;
                    else                                    state_nx = RD;
                end
            end
            RD: begin
                mem_a    = req_addr;
                state_nx = req_we ? WR : RESP;
            end
            WR: begin
                mem_a    = req_addr;
                mem_we   = 1'b1;
                mem_wd   = merged;
                state_nx = RESP;
            end
            RESP: begin
                r0_rsp_valid = !req_id;
                r1_rsp_valid = req_id;
                rsp_rdata    = buffer;
                rsp_err      = req_err;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and latched request/data buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            req_id     <= 1'b0;
            req_we     <= 1'b0;
            req_err    <= 1'b0;
            req_addr   <= 32'h0;
            req_wdata  <= 32'h0;
            req_be     <= 4'h0;
            buffer     <= 32'h0;
        end else begin
            state <= state_nx;
            if (take) begin
                last_grant <= gnt_id;
                req_id     <= gnt_id;
                req_we     <= sel_we;
                req_err    <= sel_err;
                req_addr   <= sel_addr;
                req_wdata  <= sel_wdata;
                req_be     <= sel_be;
                buffer     <= 32'h0;
            end
            if (state == RD) buffer <= mem_rd;
            if (state == WR) buffer <= merged;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port, word-addressed data memory between two requesters.
  - Requester 0: core load/store unit.
  - Requester 1: debug/program loader.
- Round-robin arbitration, valid/ready request handshake, one-cycle response pulse.
- Byte-enable stores are performed as a read-modify-write (RMW), because the memory supports whole-word writes only.
- Sits between the requesters and the data memory. The memory's read is combinational and its write is clocked; the memory does the byte-to-word address shift internally.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the data memory; byte addresses at or above MEM_WORDS*4 are out of range.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- r0_valid / r1_valid  in  1  request valid, requester 0 / 1
- r0_ready / r1_ready  out  1  request accepted this cycle
- r0_we / r1_we  in  1  1 = store, 0 = load
- r0_addr / r1_addr  in  32  byte address; bits [1:0] ignored
- r0_wdata / r1_wdata  in  32  store data
- r0_be / r1_be  in  4  store byte enables; be[i] covers bits [8i+7:8i]
- r0_rsp_valid / r1_rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  response word, shared by both requesters
- rsp_err  out  1  out-of-range error, qualified by either rsp_valid
- mem_we  out  1  data memory write enable
- mem_a  out  32  data memory byte address
- mem_wd  out  32  data memory write data
- mem_rd  in  32  data memory read data (combinational)

Behaviour:
- States: IDLE, RD, WR, RESP. Reset → IDLE.
- Reset values:
  - All outputs 0; rsp_rdata = 0; rsp_err = 0.
  - Latched request cleared.
  - last_grant = 1, so requester 0 wins the first tie.
- IDLE:
  - Arbitrate among valid requesters.
    - Only one valid: that one wins.
    - Both valid: the one not equal to last_grant wins.
  - Winner's ready = 1 combinationally, only in IDLE and not during rst. The loser's ready = 0.
  - On handshake:
    - Latch id, we, addr, wdata, be.
    - last_grant ← id.
    - Set err = (addr ≥ MEM_WORDS*4).
  - Next state:
    - err → RESP.
    - Store with be = 4'b1111 → WR.
    - Store with be = 0 → RESP; no memory access, rsp_rdata = 0.
    - Otherwise (load, or partial store) → RD.
- RD:
  - mem_a = latched addr; mem_we = 0; buffer ← mem_rd.
  - Load → RESP.
  - Partial store → WR.
- WR:
  - mem_a = latched addr; mem_we = 1.
  - mem_wd = merged word: byte i from wdata if be[i], else from buffer. For a full store, mem_wd = wdata.
  - buffer ← mem_wd.
  - → RESP.
- RESP:
  - rsp_valid of the latched id = 1 for exactly one cycle.
  - rsp_rdata = buffer:
    - load: the read word;
    - store: the word written;
    - error: 0.
  - rsp_err = err.
  - → IDLE.
- Latency, counting handshake at edge N:
  - load: rsp_valid in cycle N+2;
  - full store: N+2;
  - partial store: N+3;
  - error or be = 0: N+1.
  - Next request can be accepted the cycle after RESP.
- mem_we is 1 only in WR and never for an erroring request. mem_a = 0 and mem_wd = 0 outside RD/WR.
- No response backpressure; requesters must accept the pulse.
- Requests are never dropped. A requester holds valid and its fields stable until ready.
- A requester deasserting valid before ready is legal; nothing is latched for it.
- rst in any state:
  - Next cycle is IDLE with all outputs 0.
  - In-flight request is abandoned: no rsp_valid, no mem_we after the reset edge.
  - last_grant returns to 1.
- Simultaneous new requests during RD/WR/RESP wait; arbitration happens only in IDLE.

Test Plan:
- Full store then load:
  - r0 stores addr 0x10, wdata 0xDEADBEEF, be 4'hF → mem_we high at N+1, r0_rsp_valid at N+2.
  - r0 then loads 0x10 → rsp_rdata 0xDEADBEEF at N+2.
- Partial store:
  - Word 0x20 holds 0x11223344; r1 stores wdata 0xAABBCCDD, be 4'b0101.
  - Expect RD at N+1, WR at N+2 with mem_wd 0x11BB33DD, r1_rsp_valid at N+3.
  - A following load of 0x20 returns 0x11BB33DD.
- Contention:
  - Both valid continuously, four requests each.
  - Grants after reset alternate r0, r1, r0, r1…; no requester waits more than one transaction.
  - ready is never high for both in the same cycle.
- Out of range:
  - r0 loads 0x1000 (MEM_WORDS = 1024) → r0_rsp_valid at N+1 with rsp_err = 1, rsp_rdata = 0.
  - Store to 0x1000 leaves mem_we at 0 throughout.
- be = 0 store:
  - r0 store to 0x8, be 0 → rsp at N+1, no mem_we.
  - Word 0x8 unchanged on reload.
- Reset mid-operation:
  - Partial store reaches RD; rst asserted for one cycle.
  - No mem_we, no rsp_valid; FSM in IDLE.
  - With both requesters valid, r0 is granted first.
